// File: rtl/tlp_tx_arbiter.sv
// tlp_tx_arbiter: packet-atomic two-source TLP arbiter with a registered tx stage
module tlp_tx_arbiter #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic        pcieClk_in,
  input  logic        reset_in,
  input  logic [63:0] aData_in,
  input  logic        aSOP_in,
  input  logic        aEOP_in,
  input  logic        aValid_in,
  output logic        aReady_out,
  input  logic [63:0] bData_in,
  input  logic        bSOP_in,
  input  logic        bEOP_in,
  input  logic        bValid_in,
  output logic        bReady_out,
  output logic [63:0] txData_out,
  output logic        txSOP_out,
  output logic        txEOP_out,
  output logic        txValid_out,
  input  logic        txReady_in,
  output logic        protoErr_out
);
  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;
  state_t state;
  logic last_b;
  logic load, idle, ca, cb, any_c, pick_a, pick_b, sel_b, acc, fwd, err;
  logic [63:0] s_data;
  logic s_sop, s_eop;
  // Grant selection, same-cycle ready, and stray-beat discard in IDLE
  always_comb begin
    load = !txValid_out | txReady_in;
    idle = state == IDLE;
    ca = aValid_in & aSOP_in;
    cb = bValid_in & bSOP_in;
    any_c = ca | cb;
    pick_a = ca & (!cb | FIXED_PRIO | last_b);
    pick_b = cb & !pick_a;
    aReady_out = idle ? (any_c ? pick_a & load : aValid_in) : (state == OWN_A) & load;
    bReady_out = idle ? (any_c ? pick_b & load : bValid_in) : (state == OWN_B) & load;
    sel_b = idle ? pick_b : state == OWN_B;
    s_data = sel_b ? bData_in : aData_in;
    s_sop = sel_b ? bSOP_in : aSOP_in;
    s_eop = sel_b ? bEOP_in : aEOP_in;
    acc = sel_b ? bValid_in & bReady_out : aValid_in & aReady_out;
    fwd = acc & (!idle | any_c);
    err = idle ? !any_c & (aValid_in | bValid_in) : fwd & s_sop;
  end
  // Output register, packet ownership, round-robin memory and sticky error
  always_ff @(posedge pcieClk_in) begin
    if (reset_in) begin
      state <= IDLE;
      last_b <= 1'b1;
      txValid_out <= 1'b0;
      txSOP_out <= 1'b0;
      txEOP_out <= 1'b0;
      txData_out <= '0;
      protoErr_out <= 1'b0;
    end else begin
      txValid_out <= load ? fwd : txValid_out;
      txData_out <= fwd ? s_data : txData_out;
      txSOP_out <= fwd ? s_sop : txSOP_out;
      txEOP_out <= fwd ? s_eop : txEOP_out;
      protoErr_out <= protoErr_out | err;
      last_b <= fwd & idle ? sel_b : last_b;
      state <= !fwd ? state : s_eop ? IDLE : sel_b ? OWN_B : OWN_A;
    end
  end
endmodule

// File: tb/tb_tlp_tx_arbiter.sv
// tb_tlp_tx_arbiter: directed checks of packet arbitration, stalls and framing errors
module tb_tlp_tx_arbiter;
  logic clk = 1'b0;
  logic rst, txr;
  logic [63:0] a_d, b_d;
  logic a_v, a_s, a_e, b_v, b_s, b_e;
  logic ar0, br0, txs0, txe0, txv0, err0;
  logic ar1, br1, txs1, txe1, txv1, err1;
  logic [63:0] txd0, txd1;
  int n_chk = 0, n_err = 0, n_tx = 0, c0;

  always #5 clk = ~clk;

  tlp_tx_arbiter #(.FIXED_PRIO(1'b0)) u0 (
    .pcieClk_in(clk), .reset_in(rst),
    .aData_in(a_d), .aSOP_in(a_s), .aEOP_in(a_e), .aValid_in(a_v), .aReady_out(ar0),
    .bData_in(b_d), .bSOP_in(b_s), .bEOP_in(b_e), .bValid_in(b_v), .bReady_out(br0),
    .txData_out(txd0), .txSOP_out(txs0), .txEOP_out(txe0), .txValid_out(txv0),
    .txReady_in(txr), .protoErr_out(err0)
  );

  tlp_tx_arbiter #(.FIXED_PRIO(1'b1)) u1 (
    .pcieClk_in(clk), .reset_in(rst),
    .aData_in(a_d), .aSOP_in(a_s), .aEOP_in(a_e), .aValid_in(a_v), .aReady_out(ar1),
    .bData_in(b_d), .bSOP_in(b_s), .bEOP_in(b_e), .bValid_in(b_v), .bReady_out(br1),
    .txData_out(txd1), .txSOP_out(txs1), .txEOP_out(txe1), .txValid_out(txv1),
    .txReady_in(txr), .protoErr_out(err1)
  );

  always @(posedge clk) if (txv0 && txr) n_tx++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic sa(input logic v, input logic s, input logic e, input logic [63:0] d);
    a_v = v; a_s = s; a_e = e; a_d = d;
  endtask

  task automatic sb(input logic v, input logic s, input logic e, input logic [63:0] d);
    b_v = v; b_s = s; b_e = e; b_d = d;
  endtask

  task automatic rdy(input bit d, input string tag, input logic ea, input logic eb);
    #1;
    chk({tag, ".aready"}, d ? ar1 : ar0, ea);
    chk({tag, ".bready"}, d ? br1 : br0, eb);
  endtask

  task automatic tx(input bit d, input string tag, input logic v, input logic [63:0] dat, input logic s, input logic e);
    chk({tag, ".valid"}, d ? txv1 : txv0, v);
    if (v) begin
      chk({tag, ".data"}, d ? txd1 : txd0, dat);
      chk({tag, ".sop"}, d ? txs1 : txs0, s);
      chk({tag, ".eop"}, d ? txe1 : txe0, e);
    end
  endtask

  task automatic do_reset;
    rst = 1'b1;
    sa(0, 0, 0, 0);
    sb(0, 0, 0, 0);
    txr = 1'b1;
    tick;
    rst = 1'b0;
  endtask

  initial begin
    do_reset;
    tick;
    chk("rst.valid", txv0, 0);
    chk("rst.sop", txs0, 0);
    chk("rst.eop", txe0, 0);
    chk("rst.data", txd0, 0);
    chk("rst.err", err0, 0);
    chk("rst.valid1", txv1, 0);
    // single 3-beat packet from A
    sa(1, 1, 0, 'hA0); rdy(0, "t1c0", 1, 0); tick; tx(0, "t1b0", 1, 'hA0, 1, 0);
    sa(1, 0, 0, 'hA1); rdy(0, "t1c1", 1, 0); tick; tx(0, "t1b1", 1, 'hA1, 0, 0);
    sa(1, 0, 1, 'hA2); rdy(0, "t1c2", 1, 0); tick; tx(0, "t1b2", 1, 'hA2, 0, 1);
    sa(0, 0, 0, 0); tick; tx(0, "t1end", 0, 0, 0, 0);
    // round-robin contention: A first, then B wins the repeat
    do_reset;
    sa(1, 1, 0, 'hA0); sb(1, 1, 0, 'hB0); rdy(0, "rr0", 1, 0); tick; tx(0, "rr0", 1, 'hA0, 1, 0);
    sa(1, 0, 1, 'hA1); rdy(0, "rr1", 1, 0); tick; tx(0, "rr1", 1, 'hA1, 0, 1);
    sa(1, 1, 0, 'hC0); rdy(0, "rr2", 0, 1); tick; tx(0, "rr2", 1, 'hB0, 1, 0);
    sb(1, 0, 1, 'hB1); rdy(0, "rr3", 0, 1); tick; tx(0, "rr3", 1, 'hB1, 0, 1);
    sb(0, 0, 0, 0); rdy(0, "rr4", 1, 0); tick; tx(0, "rr4", 1, 'hC0, 1, 0);
    sa(1, 0, 1, 'hC1); rdy(0, "rr5", 1, 0); tick; tx(0, "rr5", 1, 'hC1, 0, 1);
    sa(0, 0, 0, 0); tick; tx(0, "rr6", 0, 0, 0, 0);
    // fixed priority: A wins both contentions
    do_reset;
    sa(1, 1, 0, 'hA0); sb(1, 1, 0, 'hB0); rdy(1, "fp0", 1, 0); tick; tx(1, "fp0", 1, 'hA0, 1, 0);
    sa(1, 0, 1, 'hA1); rdy(1, "fp1", 1, 0); tick; tx(1, "fp1", 1, 'hA1, 0, 1);
    sa(1, 1, 0, 'hC0); rdy(1, "fp2", 1, 0); tick; tx(1, "fp2", 1, 'hC0, 1, 0);
    sa(1, 0, 1, 'hC1); rdy(1, "fp3", 1, 0); tick; tx(1, "fp3", 1, 'hC1, 0, 1);
    sa(0, 0, 0, 0); rdy(1, "fp4", 0, 1); tick; tx(1, "fp4", 1, 'hB0, 1, 0);
    sb(1, 0, 1, 'hB1); rdy(1, "fp5", 0, 1); tick; tx(1, "fp5", 1, 'hB1, 0, 1);
    sb(0, 0, 0, 0); tick; tx(1, "fp6", 0, 0, 0, 0);
    // backpressure on a 4-beat packet
    do_reset;
    c0 = n_tx;
    sa(1, 1, 0, 'hA0); rdy(0, "st0", 1, 0); tick; tx(0, "st0", 1, 'hA0, 1, 0);
    sa(1, 0, 0, 'hA1); rdy(0, "st1", 1, 0); tick; tx(0, "st1", 1, 'hA1, 0, 0);
    txr = 1'b0;
    sa(1, 0, 0, 'hA2);
    for (int i = 0; i < 3; i++) begin
      rdy(0, "stall", 0, 0);
      tick;
      tx(0, "stall", 1, 'hA1, 0, 0);
    end
    txr = 1'b1;
    rdy(0, "st2", 1, 0); tick; tx(0, "st2", 1, 'hA2, 0, 0);
    sa(1, 0, 1, 'hA3); rdy(0, "st3", 1, 0); tick; tx(0, "st3", 1, 'hA3, 0, 1);
    sa(0, 0, 0, 0); tick; tx(0, "st4", 0, 0, 0, 0);
    chk("st.beats", 64'(n_tx - c0), 4);
    // single-beat packets alternate at full rate
    do_reset;
    sa(1, 1, 1, 'h10); sb(1, 1, 1, 'h20); rdy(0, "sb0", 1, 0); tick; tx(0, "sb0", 1, 'h10, 1, 1);
    sa(1, 1, 1, 'h11); rdy(0, "sb1", 0, 1); tick; tx(0, "sb1", 1, 'h20, 1, 1);
    sb(1, 1, 1, 'h21); rdy(0, "sb2", 1, 0); tick; tx(0, "sb2", 1, 'h11, 1, 1);
    sa(1, 1, 1, 'h12); rdy(0, "sb3", 0, 1); tick; tx(0, "sb3", 1, 'h21, 1, 1);
    chk("sb.idle", 64'(u0.state), 0);
    // stray beat without SOP, then reset mid-packet
    do_reset;
    sb(1, 0, 0, 'hBAD); rdy(0, "pe0", 0, 1); tick; tx(0, "pe0", 0, 0, 0, 0);
    chk("pe0.err", err0, 1);
    sb(0, 0, 0, 0);
    sa(1, 1, 0, 'hA0); tick; tx(0, "pe1", 1, 'hA0, 1, 0);
    sa(1, 0, 0, 'hA1); tick; tx(0, "pe2", 1, 'hA1, 0, 0);
    sa(1, 0, 0, 'hA2); rst = 1'b1; tick; rst = 1'b0;
    chk("mr.valid", txv0, 0);
    chk("mr.err", err0, 0);
    sa(1, 1, 1, 'hE0); rdy(0, "fr0", 1, 0); tick; tx(0, "fr0", 1, 'hE0, 1, 1);
    chk("fr0.err", err0, 0);
    // SOP inside an owned packet is forwarded and flagged
    sa(1, 1, 0, 'hF0); tick; tx(0, "os0", 1, 'hF0, 1, 0);
    sa(1, 1, 1, 'hF1); sb(1, 1, 0, 'hB5); rdy(0, "os1", 1, 0); tick; tx(0, "os1", 1, 'hF1, 1, 1);
    chk("os1.err", err0, 1);
    sa(0, 0, 0, 0); sb(0, 0, 0, 0); tick;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
